// File: rtl/xs3_pkg.sv
// Shared definitions for the digit-serial Excess-3 adder.
//
// Contents:
//   XS3_BIAS         Excess-3 offset (3) added to every decimal digit
//   XS3_MIN/XS3_MAX  legal Excess-3 code range (decimal 0..9)
//   state_e          sequencing states of the serial adder
//   xs3Invalid()     true when a 4-bit code is not a legal Excess-3 digit
package xs3_pkg;

    localparam logic [3:0] XS3_BIAS = 4'b0011;
    localparam logic [3:0] XS3_MIN  = 4'b0011;
    localparam logic [3:0] XS3_MAX  = 4'b1100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic logic xs3Invalid(input logic [3:0] code);
        return (code < XS3_MIN) || (code > XS3_MAX);
    endfunction

endpackage

// File: rtl/xs3_digit_add.sv
// Single-position Excess-3 digit adder (combinational).
//
// Ports:
//   a, b   operand digits, Excess-3
//   cin    decimal carry from the less-significant position
//   digit  sum digit, Excess-3
//   cout   decimal carry to the more-significant position
module xs3_digit_add
    import xs3_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] digit,
    output logic       cout
);

    logic [4:0] total;

    // The raw sum carries a double bias (6). A binary carry out means the
    // decimal sum reached 10: the remaining nibble has lost the bias, so it
    // is added back. Otherwise one extra bias is removed by adding its
    // two's complement and dropping the overflow.
    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (total[4]) begin
            digit = total[3:0] + XS3_BIAS;
        end else begin
            digit = total[3:0] + (~XS3_BIAS + 4'b0001);
        end
        cout = total[4];
    end

endmodule

// File: rtl/xs3_serial_adder.sv
// Digit-serial multi-digit Excess-3 adder.
//
// Accepts one Excess-3 digit pair per cycle, least-significant first, and
// streams the Excess-3 sum digits out through a single output register.
// The decimal carry between positions is held in a register.
//
// Parameters:
//   NDIGITS    digit positions per operation (>= 1)
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   start                 begin an operation (only honoured in IDLE)
//   in_valid/in_ready     input digit-pair handshake
//   a_digit, b_digit      operand digits, Excess-3
//   out_valid/out_ready   output digit handshake
//   sum_digit             sum digit, Excess-3
//   out_last              marks the most-significant sum digit
//   cout                  final decimal carry, only set with out_last
//   busy                  operation in progress (RUN or DRAIN)
//   err                   sticky illegal-digit flag
//
// Build option:
//   XS3_DIGIT_CHECK_EN    when defined, accepted digits outside 0011..1100
//                         set err until the next start; otherwise err is 0.
module xs3_serial_adder
    import xs3_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] a_digit,
    input  logic [3:0] b_digit,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] sum_digit,
    output logic       out_last,
    output logic       cout,
    output logic       busy,
    output logic       err
);

    localparam int              CW       = $clog2(NDIGITS + 1);
    localparam logic [CW-1:0]   LAST_IDX = CW'(NDIGITS - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic [3:0]      sum_q, sum_d;
    logic            last_q, last_d;
    logic            cout_q, cout_d;
    logic            valid_q, valid_d;

    logic            inFire;
    logic            outFire;
    logic            isLast;
    logic [3:0]      addDigit;
    logic            addCout;

    xs3_digit_add u_digit_add (
        .a     (a_digit),
        .b     (b_digit),
        .cin   (carry_q),
        .digit (addDigit),
        .cout  (addCout)
    );

    // A new digit may enter only when the single output slot is empty or
    // is being emptied in the same cycle.
    assign in_ready = (state_q == RUN) && (!valid_q || out_ready);
    assign inFire   = in_valid && in_ready;
    assign outFire  = valid_q && out_ready;
    assign isLast   = (cnt_q == LAST_IDX);

    // An acceptance overrides a drain in the same cycle, so the slot stays
    // full with the new digit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        last_d  = last_q;
        cout_d  = cout_q;
        valid_d = valid_q;

        if (outFire) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                end
            end
            RUN: begin
                if (inFire) begin
                    carry_d = addCout;
                    sum_d   = addDigit;
                    last_d  = isLast;
                    cout_d  = isLast && addCout;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + CW'(1);
                    if (isLast) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (outFire) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= 4'b0000;
            last_q  <= 1'b0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            last_q  <= last_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

`ifdef XS3_DIGIT_CHECK_EN
    logic err_q, err_d;

    // Cleared when an operation starts; set by any illegal accepted digit.
    always_comb begin
        err_d = err_q;
        if ((state_q == IDLE) && start) begin
            err_d = 1'b0;
        end else if (inFire && (xs3Invalid(a_digit) || xs3Invalid(b_digit))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign out_valid = valid_q;
    assign sum_digit = sum_q;
    assign out_last  = last_q;
    assign cout      = cout_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/xs3_serial_adder.md
# xs3_serial_adder

Digit-serial multi-digit Excess-3 adder: accepts two operands one Excess-3 digit pair per cycle, least-significant digit first, and streams out Excess-3 sum digits with the inter-digit carry held in a register. It sits directly downstream of the single-digit Excess-3 adder core. It chains that core's digit sum and carry across NDIGITS positions and presents the result on a valid/ready stream to the decimal display and packing logic.

## Interface
- NDIGITS, 4, number of digit positions per operation (≥1)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin new operation; sampled only in IDLE
- in_valid  in  1  a_digit/b_digit valid
- in_ready  out  1  digit pair accepted when in_valid && in_ready
- a_digit  in  4  operand A digit, Excess-3
- b_digit  in  4  operand B digit, Excess-3
- out_valid  out  1  sum_digit valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- sum_digit  out  4  sum digit, Excess-3
- out_last  out  1  marks most-significant sum digit
- cout  out  1  final decimal carry; meaningful only with out_last
- busy  out  1  high in RUN and DRAIN
- err  out  1  sticky illegal-digit flag (see Configuration)

## Operation
- Digit rule: t = a + b + c (5-bit binary). If t[4]=1: digit = t[3:0] + 0011, carry = 1. Else: digit = t[3:0] − 0011 (add 1101, drop overflow), carry = 0.
- Carry register c: cleared on start; updated on every accepted digit.
- FSM states:
  - IDLE: start → RUN; clears c, digit counter, err.
  - RUN: accepts digits. The NDIGITS-th acceptance → DRAIN.
  - DRAIN: holds the last output until taken, then → IDLE.
- in_ready = (state==RUN) && (!out_valid || out_ready). Single output register; no skid buffer.
- Output register loads {sum_digit, out_last, cout} on acceptance. out_last=1 only for digit index NDIGITS−1; cout = carry out of that digit. cout = 0 when out_last = 0.
- start in RUN or DRAIN is ignored.
- Counter width $clog2(NDIGITS+1). No wrap; terminal count ends RUN.

## Timing
- Reset values: in_ready=0, out_valid=0, sum_digit=4'b0000, out_last=0, cout=0, busy=0, err=0, state=IDLE, c=0.
- start at cycle 0 → RUN at cycle 1; in_ready can be high from cycle 1.
- Latency: digit accepted at edge N → out_valid/sum_digit at N+1.
- Throughput: 1 digit/cycle when out_ready is held high. Full operation takes NDIGITS+1 cycles after start.
- Output stable while out_valid && !out_ready. Simultaneous drain and new acceptance in the same cycle is allowed.
- The last digit's handshake returns the FSM to IDLE on the next edge. start may be accepted that same cycle.
- rst_n low mid-operation: immediate return to reset values. Partial results are discarded; no output handshake completes.

## Configuration
- XS3_DIGIT_CHECK_EN defined: any accepted a_digit or b_digit outside 0011..1100 sets err. err is sticky until the next start or reset. The sum is computed regardless.
- Undefined: err is tied 0 and the check logic is absent.

## Structure
- Package xs3_pkg:
  - XS3_BIAS = 4'b0011
  - XS3_MIN = 4'b0011, XS3_MAX = 4'b1100
  - state enum {IDLE, RUN, DRAIN}
- Sub-module xs3_digit_add: combinational; inputs a, b, cin; outputs digit, cout; implements the digit rule. Instantiated once.
- Top holds the FSM, counter, carry register, output register and the error check.

## Test plan
- NDIGITS=1, 0100+0100 (1+1) → sum_digit 0101, out_last=1, cout=0.
- NDIGITS=1, 1001+1001 (6+6) → sum_digit 0101, cout=1.
- NDIGITS=2, 58+67: pairs (1011,1010), (1000,1001) → 1000 then 0101 with out_last=1, cout=1 (125).
- Backpressure: out_ready low for 3 cycles after the first digit → in_ready low, sum_digit held; the stream resumes with no loss or duplication.
- With XS3_DIGIT_CHECK_EN: a_digit=0000 accepted → err=1 from the next cycle until the next start; without the macro err stays 0.
- rst_n pulsed low after the second of 4 digits → all outputs at reset values; a fresh start + 4 digits yields the correct sum.
